// File: rtl/sha256_padder.sv
// SHA-256 message padder: byte stream in, padded 512-bit blocks with first/last flags out.
// Optional SHA256_PADDER_LEN_CHECK_EN adds err_out and a saturating length counter.
module sha256_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid_in,
  input  logic         byte_last_in,
  input  logic         byte_empty_in,
  output logic         byte_ready_out,
  output logic [511:0] block_out,
  output logic         block_valid_out,
  input  logic         block_ready_in,
  output logic         first_out,
  output logic         last_out
`ifdef SHA256_PADDER_LEN_CHECK_EN
  ,
  output logic         err_out
`endif
);

  typedef enum logic [1:0] {FILL, EMIT, PAD2} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pad2_q, pad2_d;
  logic               mark_q, mark_d;   // 0x80 already placed in the emitted block
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic [511:0]       blk_q, blk_d;

  logic               accept_c, data_c, wr_c, sat_c;
  logic [6:0]         p_c;
  logic [LEN_W-1:0]   len_nxt_c;
  logic [63:0]        len_bits_c;

`ifdef SHA256_PADDER_LEN_CHECK_EN
  logic err_q;
  assign sat_c   = (len_q == {LEN_W{1'b1}});
  assign err_out = err_q;

  // Sticky overflow flag: a data byte arrived with the counter already at its maximum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else if (data_c && sat_c) err_q <= 1'b1;
  end
`else
  assign sat_c = 1'b0;
`endif

  assign accept_c   = (state_q == FILL) && ready_q && byte_valid_in;
  assign data_c     = accept_c && !(byte_last_in && byte_empty_in);
  assign wr_c       = data_c && !sat_c;
  assign p_c        = {1'b0, idx_q} + 7'(wr_c);
  assign len_nxt_c  = len_q + LEN_W'(wr_c);
  assign len_bits_c = 64'({len_nxt_c, 3'b000});

  // Next-state, block assembly and flag logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pad2_d  = pad2_q;
    mark_d  = mark_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    blk_d   = blk_q;
    unique case (state_q)
      FILL: begin
        if (accept_c) begin
          idx_d = p_c[5:0];
          len_d = len_nxt_c;
          for (int unsigned k = 0; k < 64; k++) begin
            if (wr_c && 6'(k) == idx_q)
              blk_d[8*(63-k) +: 8] = byte_in;
            else if (byte_last_in && 7'(k) == p_c)
              blk_d[8*(63-k) +: 8] = 8'h80;
            else if (byte_last_in && 7'(k) > p_c)
              blk_d[8*(63-k) +: 8] = 8'h00;
            if (byte_last_in && p_c <= 7'd55 && k >= 56)
              blk_d[8*(63-k) +: 8] = len_bits_c[8*(63-k) +: 8];
          end
          if (byte_last_in || p_c == 7'd64) begin
            state_d = EMIT;
            valid_d = 1'b1;
            ready_d = 1'b0;
            last_d  = 1'b0;
            if (byte_last_in) begin
              if (p_c == 7'd64) begin
                pad2_d = 1'b1;
                mark_d = 1'b0;
              end else if (p_c <= 7'd55) begin
                last_d = 1'b1;
              end else begin
                pad2_d = 1'b1;
                mark_d = 1'b1;
              end
            end
          end
        end
      end
      EMIT: begin
        if (block_ready_in) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          if (pad2_q) begin
            state_d = PAD2;
          end else begin
            state_d = FILL;
            ready_d = 1'b1;
            idx_d   = '0;
            if (last_q) begin
              first_d = 1'b1;
              len_d   = '0;
            end
          end
        end
      end
      PAD2: begin
        blk_d          = '0;
        blk_d[511:504] = mark_q ? 8'h00 : 8'h80;
        blk_d[63:0]    = len_bits_c;
        last_d         = 1'b1;
        pad2_d         = 1'b0;
        valid_d        = 1'b1;
        state_d        = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FILL;
      idx_q   <= '0;
      len_q   <= '0;
      pad2_q  <= 1'b0;
      mark_q  <= 1'b0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pad2_q  <= pad2_d;
      mark_q  <= mark_d;
      first_q <= first_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      blk_q   <= blk_d;
    end
  end

  assign byte_ready_out  = ready_q;
  assign block_valid_out = valid_q;
  assign block_out       = blk_q;
  assign first_out       = first_q;
  assign last_out        = last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: table of messages with hand-computed block words.
module tb_sha256_padder;

  logic         CLK = 1'b0;
  logic         RST;
  logic [7:0]   byte_in;
  logic         byte_valid_in, byte_last_in, byte_empty_in;
  logic         byte_ready_out;
  logic [511:0] block_out;
  logic         block_valid_out;
  logic         block_ready_in;
  logic         first_out, last_out;
`ifdef SHA256_PADDER_LEN_CHECK_EN
  logic         err_out;
`endif

  sha256_padder #(.LEN_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_last_in(byte_last_in), .byte_empty_in(byte_empty_in),
    .byte_ready_out(byte_ready_out),
    .block_out(block_out), .block_valid_out(block_valid_out),
    .block_ready_in(block_ready_in),
    .first_out(first_out), .last_out(last_out)
`ifdef SHA256_PADDER_LEN_CHECK_EN
    , .err_out(err_out)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } rec_t;

  // Per block: words 0, 13, 14, 15 plus flags.
  typedef struct packed {
    logic [7:0]             n;
    logic [1:0]             mode;   // 0: 0x41 fill, 1: "abc..", 2: "abc.." then empty last beat
    logic [1:0]             nblk;
    logic [1:0][3:0][31:0]  w;
    logic [1:0]             f;
    logic [1:0]             l;
  } vec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Record each block at the negedge before its handshake edge.
  always @(negedge CLK)
    if (!RST && block_valid_out && block_ready_in)
      q.push_back('{blk: block_out, first: first_out, last: last_out});

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] b, input logic l, input logic e);
    int t = 0;
    @(negedge CLK);
    byte_in = b; byte_valid_in = 1'b1; byte_last_in = l; byte_empty_in = e;
    while (!byte_ready_out && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout got ready=0 want ready=1");
    end
    @(posedge CLK);
    #1;
    byte_valid_in = 1'b0; byte_last_in = 1'b0; byte_empty_in = 1'b0;
  endtask

  task automatic send_msg(input int n, input int mode);
    for (int i = 0; i < n; i++)
      send_beat((mode != 0) ? 8'h61 + 8'(i) : 8'h41, (i == n - 1) && (mode != 2), 1'b0);
    if (n == 0 || mode == 2) send_beat(8'h00, 1'b1, 1'b1);
  endtask

  task automatic wait_blocks(input int nb);
    int t = 0;
    while (q.size() < nb && t < 300) begin
      @(negedge CLK);
      t++;
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    q.delete();
    send_msg(int'(v.n), int'(v.mode));
    wait_blocks(int'(v.nblk));
    check({name, ".nblk"}, 512'(q.size()), 512'(v.nblk));
    for (int b = 0; b < int'(v.nblk) && b < q.size(); b++) begin
      check($sformatf("%s.b%0d.w0", name, b),  512'(q[b].blk[511:480]), 512'(v.w[b][0]));
      check($sformatf("%s.b%0d.w13", name, b), 512'(q[b].blk[95:64]),   512'(v.w[b][1]));
      check($sformatf("%s.b%0d.w14", name, b), 512'(q[b].blk[63:32]),   512'(v.w[b][2]));
      check($sformatf("%s.b%0d.w15", name, b), 512'(q[b].blk[31:0]),    512'(v.w[b][3]));
      check($sformatf("%s.b%0d.first", name, b), 512'(q[b].first), 512'(v.f[b]));
      check($sformatf("%s.b%0d.last", name, b),  512'(q[b].last),  512'(v.l[b]));
    end
  endtask

  function automatic vec_t mk(input int n, input int mode, input int nb,
                              input logic [31:0] a0, a1, a2, a3,
                              input logic [31:0] b0, b1, b2, b3,
                              input logic [1:0] f, input logic [1:0] l);
    vec_t v;
    v.n = 8'(n); v.mode = 2'(mode); v.nblk = 2'(nb);
    v.w[0][0] = a0; v.w[0][1] = a1; v.w[0][2] = a2; v.w[0][3] = a3;
    v.w[1][0] = b0; v.w[1][1] = b1; v.w[1][2] = b2; v.w[1][3] = b3;
    v.f = f; v.l = l;
    return v;
  endfunction

  task automatic check_reset_vals(input string name);
    check({name, ".ready"}, 512'(byte_ready_out),  512'(1));
    check({name, ".valid"}, 512'(block_valid_out), 512'(0));
    check({name, ".block"}, block_out,             512'(0));
    check({name, ".first"}, 512'(first_out),       512'(1));
    check({name, ".last"},  512'(last_out),        512'(0));
  endtask

  vec_t vecs[8];
  string names[8];
  vec_t abc_v;

  initial begin
    RST = 1'b1; byte_in = '0; byte_valid_in = 1'b0; byte_last_in = 1'b0;
    byte_empty_in = 1'b0; block_ready_in = 1'b1;

    abc_v = mk(3, 1, 1, 32'h61626380, 0, 0, 32'h18, 0, 0, 0, 0, 2'b01, 2'b01);
    names[0] = "abc";    vecs[0] = abc_v;
    names[1] = "empty";  vecs[1] = mk(0, 0, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01);
    names[2] = "len55";  vecs[2] = mk(55, 0, 1, 32'h41414141, 32'h41414180, 0, 32'h1B8,
                                      0, 0, 0, 0, 2'b01, 2'b01);
    names[3] = "len56";  vecs[3] = mk(56, 0, 2, 32'h41414141, 32'h41414141, 32'h80000000, 0,
                                      0, 0, 0, 32'h1C0, 2'b01, 2'b10);
    names[4] = "len60";  vecs[4] = mk(60, 0, 2, 32'h41414141, 32'h41414141, 32'h41414141,
                                      32'h80000000, 0, 0, 0, 32'h1E0, 2'b01, 2'b10);
    names[5] = "len64";  vecs[5] = mk(64, 0, 2, 32'h41414141, 32'h41414141, 32'h41414141,
                                      32'h41414141, 32'h80000000, 0, 0, 32'h200, 2'b01, 2'b10);
    names[6] = "abc2";   vecs[6] = abc_v;
    names[7] = "abclate"; vecs[7] = mk(3, 2, 1, 32'h61626380, 0, 0, 32'h18, 0, 0, 0, 0,
                                       2'b01, 2'b01);

    repeat (2) @(negedge CLK);
    check_reset_vals("rst_hold");
    RST = 1'b0;
    @(negedge CLK);
    check_reset_vals("after_rst");

    for (int i = 0; i < 8; i++) run_vec(names[i], vecs[i]);

    // Backpressure: block must be held with ready low for 10 cycles.
    q.delete();
    block_ready_in = 1'b0;
    send_msg(3, 1);
    check("bp.latency", 512'(block_valid_out), 512'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      check("bp.w0",    512'(block_out[511:480]), 512'(32'h61626380));
      check("bp.w15",   512'(block_out[31:0]),    512'(32'h18));
      check("bp.valid", 512'(block_valid_out),    512'(1));
      check("bp.ready", 512'(byte_ready_out),     512'(0));
    end
    @(posedge CLK); #1;
    block_ready_in = 1'b1;
    wait_blocks(1);
    check("bp.nblk", 512'(q.size()), 512'(1));

    // Reset mid-fill.
    q.delete();
    for (int i = 0; i < 10; i++) send_beat(8'h41, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check_reset_vals("rst_fill");
    @(negedge CLK);
    RST = 1'b0;

    // Reset mid-EMIT: valid must drop without a clock edge.
    block_ready_in = 1'b0;
    send_msg(3, 1);
    check("emit.valid_pre", 512'(block_valid_out), 512'(1));
    #2;
    RST = 1'b1;
    #1;
    check_reset_vals("rst_emit");
    @(negedge CLK);
    RST = 1'b0;
    block_ready_in = 1'b1;
    q.delete();
    run_vec("abc_post_rst", abc_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream front end of the SHA-256 core. It accepts a message as a byte stream and applies standard SHA-256 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. It emits 512-bit blocks, each with first/last flags, over a valid/ready handshake. The core controller uses these flags to choose the IV on the first block and to know when the digest is final.

## Interface
- LEN_W, 32: width of the internal byte counter; maximum message length is 2^LEN_W−1 bytes.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- byte_in  in  8  message byte.
- byte_valid_in  in  1  byte beat valid.
- byte_last_in  in  1  beat ends the message.
- byte_empty_in  in  1  only meaningful with byte_last_in; the beat carries no data byte (used for zero-length messages or late end marking).
- byte_ready_out  out  1  beat accepted when byte_valid_in && byte_ready_out.
- block_out  out  512  padded block; word 0 at [511:480], word 15 at [31:0], big-endian bytes.
- block_valid_out  out  1  block available.
- block_ready_in  in  1  block consumed when block_valid_out && block_ready_in.
- first_out  out  1  block is the first of its message; valid with block_valid_out.
- last_out  out  1  block is the final block of its message; valid with block_valid_out.

## Operation
- States: FILL, EMIT, PAD2.
- FILL:
  - byte_ready_out = 1.
  - Each accepted data byte is written at position idx (0..63); idx and len both increment.
  - A byte accepted at idx=63 without last → EMIT, first_out as held, last_out=0.
  - A last beat (data byte written first, unless byte_empty_in) → padding in the same cycle:
    - 0x80 is placed at p = new idx, bytes p+1..63 are zeroed, and len_bits = len×8.
    - If p ≤ 55: length goes in bytes 56..63 → EMIT with last_out=1.
    - If p ≥ 56: → EMIT with last_out=0, and pad2_pending is set.
    - If a full block (idx=63 plus data byte) ends with last: the block is emitted as-is with last_out=0, pad2_pending is set, and the 0x80 goes into the second block.
- EMIT:
  - byte_ready_out = 0; block_out and flags are held stable.
  - On handshake: first_out is cleared.
    - If pad2_pending → PAD2.
    - Otherwise, if last_out was set, first_flag is set to 1, idx and len are cleared → FILL.
    - Otherwise idx is cleared → FILL.
- PAD2:
  - Builds the extra block in one cycle: byte 0 is 0x80 if the 0x80 was not yet placed, else 0x00; zeros follow; length in bytes 56..63.
  - Then → EMIT with last_out=1 and pad2_pending cleared.
- Length: len is LEN_W bits. Bit length = {len, 3'b000}, zero-extended to 64 bits. A LEN_W-bit wrap is unchecked unless the configuration macro is defined.

## Timing
- Reset values:
  - byte_ready_out=1, block_valid_out=0, block_out=0, first_out=1, last_out=0.
  - State FILL; idx, len and pad2_pending all 0.
- Latency:
  - The block-completing byte handshake at edge N gives block_valid_out=1 after edge N.
  - The PAD2 block follows 1 idle cycle after the first block's handshake.
- block_valid_out stays high until consumed; block_out must not change while it is high.
- No bytes are accepted while in EMIT or PAD2; back-to-back messages incur no extra gap beyond EMIT.
- byte_ready_out is a registered state decode; it has no combinational path from block_ready_in.
- Reset mid-message or mid-EMIT:
  - Any partial block is discarded; there is no partial output.
  - block_valid_out drops asynchronously.

## Configuration
- SHA256_PADDER_LEN_CHECK_EN defined:
  - Adds the output err_out (1 bit, reset 0).
  - Accepting a data byte while len = 2^LEN_W−1 sets err_out (sticky until RST); the byte is dropped.
  - len saturates and the message still completes with the saturated length.
- Undefined: no err_out port, and len wraps silently.

## Test plan
- "abc" (61 62 63, last on 63) → one block: word0=61626380, words1..14=0, word15=00000018, first=last=1.
- Empty message (single beat with last=1, empty=1) → word0=80000000, word15=00000000, first=last=1.
- 55 bytes of 0x41 → one block, byte55=0x80, word15=000001B8, last=1.
- 56 bytes → two blocks:
  - Block 1: first=1, last=0, byte56=0x80.
  - Block 2: first=0, last=1, words0..14=0, word15=000001C0.
- 64 bytes, then a second message "abc":
  - First message: block 2 word0=80000000, word15=00000200.
  - Next message block: first_out=1 again.
- Backpressure and reset:
  - Hold block_ready_in=0 for 10 cycles → block_out stable, byte_ready_out=0.
  - Assert RST mid-fill → all outputs return to reset values.
  - A subsequent "abc" gives the exact result of the first scenario.
